// File: rtl/note_entry_if.sv
// Board-side signal bundle for note_entry_conditioner: raw switch/button inputs,
// the recognizer finish flag, conditioned entry outputs and the debounce FSM state.
interface note_entry_if;
  logic        ok_raw;
  logic        tone_raw;
  logic [2:0]  note_raw;
  logic        finish_n;
  logic        ok_pulse;
  logic        tone_out;
  logic [2:0]  note_out;
  logic [2:0]  note_count;
  logic        locked;
  logic [14:0] history;
  logic [1:0]  fsm_state;

  // Handshake: ok_pulse is a single-cycle strobe with no ready; tone_out/note_out
  // are valid in the ok_pulse cycle and stay stable until the next ok_pulse.
  modport master (
    output ok_raw, tone_raw, note_raw, finish_n,
    input  ok_pulse, tone_out, note_out, note_count, locked, history, fsm_state
  );

  modport slave (
    input  ok_raw, tone_raw, note_raw, finish_n,
    output ok_pulse, tone_out, note_out, note_count, locked, history, fsm_state
  );
endinterface

// File: rtl/note_entry_conditioner.sv
// Synchronizes and debounces raw note-entry inputs into single-cycle entries for the
// recognizer; optional note history is enabled by defining NOTE_HISTORY_EN.
module note_entry_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input logic         clk,
  input logic         reset,
  note_entry_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ok_m, ok_s;
  logic             tone_m, tone_s;
  logic [2:0]       note_m, note_s;
  logic             ok_pulse_q;
  logic             tone_q;
  logic [2:0]       note_q;
  logic [2:0]       count_q;
  logic             locked_q;
  logic             accept;
  logic             take;

  // A finish flag on the accepting edge wins over the press.
  assign accept = (state == PRESS_WAIT) && ok_s && (cnt == CNT_LAST);
  assign take   = accept && !locked_q && bus.finish_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      ok_m       <= 1'b0;
      ok_s       <= 1'b0;
      tone_m     <= 1'b0;
      tone_s     <= 1'b0;
      note_m     <= 3'd0;
      note_s     <= 3'd0;
      state      <= IDLE;
      cnt        <= '0;
      ok_pulse_q <= 1'b0;
      tone_q     <= 1'b0;
      note_q     <= 3'd0;
      count_q    <= 3'd0;
      locked_q   <= 1'b0;
    end else begin
      ok_m   <= bus.ok_raw;
      ok_s   <= ok_m;
      tone_m <= bus.tone_raw;
      tone_s <= tone_m;
      note_m <= bus.note_raw;
      note_s <= note_m;

      ok_pulse_q <= take;
      if (take) begin
        tone_q  <= tone_s;
        note_q  <= note_s;
        count_q <= (count_q == 3'd7) ? 3'd7 : count_q + 3'd1;
      end
      if (!bus.finish_n) locked_q <= 1'b1;

      case (state)
        IDLE: begin
          if (ok_s) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!ok_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!ok_s) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (ok_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef NOTE_HISTORY_EN
  logic [14:0] history_q;

  // Newest note enters at [2:0]; suppressed presses leave the history untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      history_q <= 15'd0;
    end else if (take) begin
      history_q <= {history_q[11:0], note_s};
    end
  end

  assign bus.history = history_q;
`else
  assign bus.history = 15'd0;
`endif

  assign bus.ok_pulse   = ok_pulse_q;
  assign bus.tone_out   = tone_q;
  assign bus.note_out   = note_q;
  assign bus.note_count = count_q;
  assign bus.locked     = locked_q;
  assign bus.fsm_state  = state;
endmodule

// File: tb/tb_note_entry_conditioner.sv
// Scoreboarded bench for note_entry_conditioner: a run-length debounce model predicts
// accepted entries; a negedge monitor pops and compares on every ok_pulse.
module tb_note_entry_conditioner;
  localparam int D = 4;
  localparam int W = 22;
`ifdef NOTE_HISTORY_EN
  localparam logic [14:0] HIST_EXP = 15'b100_001_110_101_000;
`else
  localparam logic [14:0] HIST_EXP = 15'd0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  note_entry_if bus();

  note_entry_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = -1;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Debounced level flips after D consecutive synchronized samples of the opposite
  // value; a flip to "pressed" is an entry unless locked or finish_n is low.
  logic        m_ok1 = 0, m_ok2 = 0, m_tone1 = 0, m_tone2 = 0;
  logic [2:0]  m_note1 = 0, m_note2 = 0;
  logic        m_level = 0;
  int          m_run = 0;
  logic        m_locked = 0, m_pulse = 0, m_tone = 0;
  logic [2:0]  m_note = 0;
  int          m_count = 0;
  logic [14:0] m_hist = 0;

  always @(posedge clk) begin
    cyc++;
    m_pulse = 1'b0;
    if (reset) begin
      m_ok1 = 0; m_ok2 = 0; m_tone1 = 0; m_tone2 = 0; m_note1 = 0; m_note2 = 0;
      m_level = 0; m_run = 0; m_locked = 0; m_tone = 0; m_note = 0;
      m_count = 0; m_hist = 0;
    end else begin
      if (m_ok2 != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = m_ok2;
          m_run   = 0;
          if (m_level && !m_locked && bus.finish_n) begin
            m_pulse = 1'b1;
            m_tone  = m_tone2;
            m_note  = m_note2;
            if (m_count < 7) m_count++;
`ifdef NOTE_HISTORY_EN
            m_hist = {m_hist[11:0], m_note2};
`endif
            exp_q.push_back({m_tone, m_note, 3'(m_count), m_hist});
          end
        end
      end else begin
        m_run = 0;
      end
      if (!bus.finish_n) m_locked = 1'b1;
      m_ok2 = m_ok1;     m_ok1 = bus.ok_raw;
      m_tone2 = m_tone1; m_tone1 = bus.tone_raw;
      m_note2 = m_note1; m_note1 = bus.note_raw;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] got_w, exp_w;
  always @(negedge clk) begin
    chk("pulse", {31'd0, bus.ok_pulse}, {31'd0, m_pulse});
    chk("outputs", {9'd0, bus.locked, bus.note_count, bus.tone_out, bus.note_out, bus.history},
        {9'd0, m_locked, 3'(m_count), m_tone, m_note, m_hist});
    if (bus.ok_pulse === 1'b1) begin
      pulses++;
      last_pulse_cyc = cyc;
      got_w = {bus.tone_out, bus.note_out, bus.note_count, bus.history};
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {10'd0, got_w}, 32'hFFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        chk("entry", {10'd0, got_w}, {10'd0, exp_w});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ok(input logic v, input int n);
    bus.ok_raw = v;
    tick(n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic clean_press(input logic t, input logic [2:0] n);
    bus.tone_raw = t;
    bus.note_raw = n;
    drive_ok(1'b1, D + 4);
    drive_ok(1'b0, D + 4);
  endtask

  // ---------------- stimulus ----------------
  int e0;
  int p0;
  int nb;
  logic [2:0] hist_notes [5];

  initial begin
    bus.ok_raw   = 1'b0;
    bus.tone_raw = 1'b0;
    bus.note_raw = 3'd0;
    bus.finish_n = 1'b1;
    tick(3);
    reset = 1'b0;
    chk("reset_state", {9'd0, bus.locked, bus.note_count, bus.tone_out, bus.note_out, bus.history}, 32'd0);

    // clean press with latency check
    bus.note_raw = 3'b100;
    p0 = pulses;
    e0 = cyc + 1;
    drive_ok(1'b1, 20);
    chk("latency", last_pulse_cyc, e0 + 5);
    chk("clean_one_pulse", pulses - p0, 1);
    chk("clean_fields", {25'd0, bus.tone_out, bus.note_out, bus.note_count}, {25'd0, 1'b0, 3'b100, 3'd1});
    drive_ok(1'b0, 10);

    // bounce on press, bounce on release
    do_reset();
    bus.tone_raw = 1'b1;
    bus.note_raw = 3'b010;
    p0 = pulses;
    drive_ok(1, 1); drive_ok(0, 1); drive_ok(1, 1); drive_ok(1, 1); drive_ok(0, 1); drive_ok(1, 1);
    drive_ok(1, 12);
    chk("bounce_press_pulses", pulses - p0, 1);
    drive_ok(0, 1); drive_ok(1, 1); drive_ok(0, 1); drive_ok(0, 1); drive_ok(1, 1);
    drive_ok(0, 10);
    chk("bounce_release_pulses", pulses - p0, 1);
    chk("release_idle", {30'd0, bus.fsm_state}, 32'd0);
    clean_press(1'b0, 3'b011);
    chk("count_two", {29'd0, bus.note_count}, 32'd2);

    // lock
    bus.finish_n = 1'b0;
    tick(1);
    bus.finish_n = 1'b1;
    chk("locked_set", {31'd0, bus.locked}, 32'd1);
    p0 = pulses;
    clean_press(1'b1, 3'b101);
    chk("locked_no_pulse", pulses - p0, 0);
    chk("locked_hold", {26'd0, bus.tone_out, bus.note_out, bus.note_count}, {26'd0, 1'b0, 3'b011, 3'd2});
    do_reset();
    chk("unlock_reset", {28'd0, bus.locked, bus.note_count}, 32'd0);

    // saturation
    p0 = pulses;
    for (int i = 0; i < 9; i++) begin
      clean_press(i[0], 3'(i));
      if (i == 6) chk("sat_at_7", {29'd0, bus.note_count}, 32'd7);
    end
    chk("sat_pulses", pulses - p0, 9);
    chk("sat_stays", {29'd0, bus.note_count}, 32'd7);

    // reset mid-press
    p0 = pulses;
    bus.note_raw = 3'b110;
    drive_ok(1'b1, 3);
    chk("in_press_wait", {30'd0, bus.fsm_state}, 32'd1);
    reset = 1'b1;
    bus.ok_raw = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(D + 4);
    chk("midpress_no_pulse", pulses - p0, 0);
    chk("midpress_zero", {9'd0, bus.locked, bus.note_count, bus.tone_out, bus.note_out, bus.history}, 32'd0);

    // history
    hist_notes = '{3'b100, 3'b001, 3'b110, 3'b101, 3'b000};
    for (int i = 0; i < 5; i++) clean_press(1'b0, hist_notes[i]);
    chk("history", {17'd0, bus.history}, {17'd0, HIST_EXP});

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 59) == 0 || (m_locked && $urandom_range(0, 3) == 0)) do_reset();
      if ($urandom_range(0, 39) == 0) begin
        bus.finish_n = 1'b0;
        tick(1);
        bus.finish_n = 1'b1;
      end
      bus.tone_raw = 1'($urandom_range(0, 1));
      bus.note_raw = 3'($urandom_range(0, 7));
      nb = $urandom_range(0, 3);
      repeat (nb) begin
        drive_ok(1'b1, $urandom_range(1, 3));
        drive_ok(1'b0, $urandom_range(1, 2));
      end
      drive_ok(1'b1, $urandom_range(1, D + 3));
      bus.note_raw = 3'($urandom_range(0, 7));
      bus.tone_raw = 1'($urandom_range(0, 1));
      drive_ok(1'b1, $urandom_range(1, 4));
      nb = $urandom_range(0, 2);
      repeat (nb) begin
        drive_ok(1'b0, $urandom_range(1, 3));
        drive_ok(1'b1, $urandom_range(1, 2));
      end
      drive_ok(1'b0, $urandom_range(D + 2, D + 6));
    end

    tick(10);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_entry_conditioner.md
Name: note_entry_conditioner

Overview:
- Front-end stage that sits directly upstream of the note-sequence recognizer FSM. It turns raw board inputs (ok pushbutton, tone switch, 3-bit note switches) into clean, synchronous, single-cycle entries for that FSM.
- Synchronizes all inputs, debounces the ok button and emits exactly one ok_pulse per physical press, with tone/note captured and held stable.
- Counts entries and locks out further entries once the recognizer reports completion.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive synchronized-stable samples needed to accept a press or release (minimum 2).
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, width of the debounce counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ok_raw  input  1  raw pushbutton, asynchronous, bouncy, 1 = pressed
- tone_raw  input  1  raw tone switch, asynchronous
- note_raw  input  3  raw note switches, asynchronous; 000=x, 001=c, 010=d, 011=e, 100=f, 101=g, 110=a, 111=b
- finish_n  input  1  recognizer finish flag, active-low (0 = sequence finished)
- ok_pulse  output  1  one-cycle entry strobe to the recognizer
- tone_out  output  1  tone value captured with the last ok_pulse
- note_out  output  3  note value captured with the last ok_pulse
- note_count  output  3  accepted entries since reset, saturating at 7
- locked  output  1  1 = entries suppressed until reset
- history  output  15  last five accepted notes (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high, overrides everything, legal mid-debounce or mid-press):
  - All outputs go to 0.
  - Synchronizer flops go to 0, debounce counter goes to 0, FSM goes to IDLE.
- Synchronizers:
  - Each of ok_raw, tone_raw and note_raw passes through 2 flip-flops; the second-stage values are ok_s, tone_s and note_s.
  - note_s is only ever sampled at accept time, so multi-bit skew is harmless.
- Debounce FSM (4 states):
  - IDLE: if ok_s=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - ok_s=0: return to IDLE, cnt=0.
    - ok_s=1 and cnt=DEBOUNCE_CYCLES-1: go to PRESSED and accept the press.
    - Otherwise increment cnt.
  - PRESSED: if ok_s=0, go to RELEASE_WAIT with cnt=1. Holding the button never produces a second pulse.
  - RELEASE_WAIT:
    - ok_s=1 (bounce): return to PRESSED, with no pulse.
    - ok_s=0 and cnt=DEBOUNCE_CYCLES-1: go to IDLE.
    - Otherwise increment cnt.
- Accept (registered):
  - On the accepting edge, if locked=0 and finish_n=1: ok_pulse<=1 for exactly one cycle, tone_out<=tone_s, note_out<=note_s, and note_count<=min(note_count+1,7).
  - If the press is suppressed, the FSM still moves to PRESSED, but ok_pulse, tone_out, note_out and note_count are unchanged.
- Latency: if ok_raw is first sampled high at edge e0 and held, ok_pulse is high during the cycle following edge e0+DEBOUNCE_CYCLES+1.
- tone_out and note_out hold their value until the next accepted press, independent of later switch changes.
- Lock:
  - At any edge where finish_n=0, locked<=1. locked is sticky and cleared only by reset.
  - Simultaneous finish_n=0 and accept: finish_n wins, so no pulse is issued.
- note_count: 3-bit, saturates at 7 and never wraps.

Optional Feature:
- Macro: NOTE_HISTORY_EN.
- Defined:
  - history is a 5-deep shift register of 3-bit notes, newest in [2:0] and oldest in [14:12].
  - It shifts left by 3 and loads note_s on every ok_pulse.
  - Reset value is 0. It is not shifted on suppressed presses.
- Undefined: history is tied to 15'b0 and no history registers are inferred. All other behaviour is identical.

Test Plan:
- Clean press (DEBOUNCE_CYCLES=4): reset, then tone_raw=0, note_raw=100, ok_raw high at edge e0 and held 20 cycles -> ok_pulse high only in the cycle after edge e0+5, tone_out=0, note_out=100, note_count=1.
- Bounce on press (D=4): ok_raw pattern 1,0,1,1,0,1 then held high -> no pulse during the glitches, exactly one pulse after 4 stable ok_s samples.
- Bounce on release (D=4): after an accepted press, ok_raw pattern 0,1,0,0,1 then held low 10 cycles -> no second pulse; FSM reaches IDLE; the next clean press gives a pulse and note_count=2.
- Lock (D=4): drive finish_n=0 for 1 cycle -> locked=1 next cycle; a subsequent clean press with note_raw=101 gives no pulse, note_out unchanged, note_count unchanged; reset -> locked=0, note_count=0.
- Saturation and reset mid-press (D=4):
  - 9 clean presses -> note_count=7 after the 7th press and stays 7; ok_pulse still fires on presses 8 and 9.
  - Reset asserted while in PRESS_WAIT -> no pulse, all outputs 0.
- With NOTE_HISTORY_EN (D=4): accept notes 100, 001, 110, 101, 000 in order -> history = 100_001_110_101_000. Without the macro -> history=0 throughout.
